// File: rtl/serial_stream_gen_pkg.sv
// -----------------------------------------------------------------------------
// serial_gen_pkg
// Shared definitions for the serial stimulus generator: FSM state encoding,
// default word/divisor widths and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_gen_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 24;
  localparam int DEFAULT_DIV_W = 8;

  // Width of a counter that must hold the values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_stream_gen_if.sv
// -----------------------------------------------------------------------------
// serial_stream_gen_if
// Word-load handshake between a stimulus source and serial_stream_gen.
// Signals:
//   load_valid  source -> generator  request to load a word
//   load_ready  generator -> source  generator idle and able to accept
//   load_data   source -> generator  word to send, MSB first
//   load_repeat source -> generator  1 = rotate the word continuously
//   load_div    source -> generator  each bit lasts load_div+1 cycles
// Modports: master (stimulus source), slave (generator).
// -----------------------------------------------------------------------------
import serial_gen_pkg::*;

interface serial_stream_gen_if #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV_W = DEFAULT_DIV_W
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             load_repeat;
  logic [DIV_W-1:0] load_div;

  modport master (
    output load_valid,
    output load_data,
    output load_repeat,
    output load_div,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_repeat,
    input  load_div,
    output load_ready
  );

endinterface

// File: rtl/serial_stream_gen_bit_rate_div.sv
// -----------------------------------------------------------------------------
// bit_rate_div
// Bit-period counter for the serial generator. Counts 0..div_i while enabled
// and marks the first and last cycle of every bit period.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr_i      restart the count at 0 (word accepted)
//   en_i       count enable (generator shifting)
//   div_i      last count value of a bit period
//   tick_o     last cycle of the current bit (bit boundary)
//   first_o    first cycle of the current bit
// -----------------------------------------------------------------------------
import serial_gen_pkg::*;

module bit_rate_div #(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic             first_o
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  // Next count: clear on accept, wrap to 0 on the programmed last value.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr_i) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      if (div_cnt_q == div_i) begin
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick_o  = en_i && (div_cnt_q == div_i);
  assign first_o = en_i && (div_cnt_q == '0);

endmodule

// File: rtl/serial_stream_gen.sv
// -----------------------------------------------------------------------------
// serial_stream_gen
// Accepts a parallel word over a valid/ready handshake and emits it MSB-first
// as a one-bit stream, one bit per div+1 clocks, either once or rotating
// continuously until stop is seen (the current word always completes).
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        word-load handshake (serial_stream_gen_if.slave)
//   stop        in repeat mode, end the stream after the current word
//   x           serial bit, 0 whenever x_valid is low
//   x_valid     a bit is being driven
//   bit_strobe  first cycle of each bit
//   busy        generator is shifting
//   done        one-cycle pulse in the first idle cycle after a stream
// -----------------------------------------------------------------------------
import serial_gen_pkg::*;

module serial_stream_gen #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic                clk,
  input  logic                rst,
  serial_stream_gen_if.slave  load,
  input  logic                stop,
  output logic                x,
  output logic                x_valid,
  output logic                bit_strobe,
  output logic                busy,
  output logic                done
);

  localparam int BIT_W = cnt_width(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_t           state_q,        state_d;
  logic [WIDTH-1:0] sh_q,           sh_d;
  logic             rep_q,          rep_d;
  logic [DIV_W-1:0] div_q,          div_d;
  logic [BIT_W-1:0] bit_cnt_q,      bit_cnt_d;
  logic             stop_pending_q, stop_pending_d;
  logic             done_q,         done_d;

  logic accept_s;
  logic shifting_s;
  logic tick_s;
  logic first_s;

  assign shifting_s = (state_q == SHIFT);
  assign accept_s   = load.load_valid && (state_q == IDLE);

  bit_rate_div #(
    .DIV_W (DIV_W)
  ) u_bit_rate_div (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept_s),
    .en_i    (shifting_s),
    .div_i   (div_q),
    .tick_o  (tick_s),
    .first_o (first_s)
  );

  // Next-state logic: load on accept, rotate on bit boundaries, decide at word end.
  always_comb begin
    state_d        = state_q;
    sh_d           = sh_q;
    rep_d          = rep_q;
    div_d          = div_q;
    bit_cnt_d      = bit_cnt_q;
    stop_pending_d = stop_pending_q;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sh_d           = load.load_data;
          rep_d          = load.load_repeat;
          div_d          = load.load_div;
          bit_cnt_d      = '0;
          stop_pending_d = 1'b0;
          state_d        = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end else begin
          stop_pending_d = stop_pending_q;
        end
        if (tick_s) begin
          // Rotate rather than shift so a repeated word reappears intact.
          sh_d = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
          if (bit_cnt_q == LAST_BIT) begin
            // The live stop input counts too, so a stop in the last cycle still ends this word.
            if (rep_q && !stop_pending_q && !stop) begin
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          sh_d = sh_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sh_q           <= '0;
      rep_q          <= 1'b0;
      div_q          <= '0;
      bit_cnt_q      <= '0;
      stop_pending_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_q           <= sh_d;
      rep_q          <= rep_d;
      div_q          <= div_d;
      bit_cnt_q      <= bit_cnt_d;
      stop_pending_q <= stop_pending_d;
      done_q         <= done_d;
    end
  end

  assign load.load_ready = (state_q == IDLE);
  assign x_valid         = shifting_s;
  assign busy            = shifting_s;
  assign x               = shifting_s && sh_q[WIDTH-1];
  assign bit_strobe      = first_s;
  assign done            = done_q;

endmodule

// File: tb/tb_serial_stream_gen.sv
module tb_serial_stream_gen;

  localparam int W  = 24;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic stop;
  logic x;
  logic x_valid;
  logic bit_strobe;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  serial_stream_gen_if #(.WIDTH(W), .DIV_W(DW)) lif ();

  serial_stream_gen #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (lif),
    .stop       (stop),
    .x          (x),
    .x_valid    (x_valid),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural model: stream position in cycles since the accept.
  bit           m_active = 1'b0;
  bit           m_done   = 1'b0;
  bit           m_rep    = 1'b0;
  bit           m_stop   = 1'b0;
  logic [W-1:0] m_word   = '0;
  int           m_div    = 0;
  int           m_t      = 0;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int vcnt     = 0;
  int scnt     = 0;
  int dcnt     = 0;
  int done_cyc = 0;
  logic [127:0] cap = '0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance the model across one rising edge, using the inputs seen at that edge.
  task automatic model_step();
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_stop   = 1'b0;
    end else if (m_active) begin
      m_done = 1'b0;
      if (stop) m_stop = 1'b1;
      if ((((m_t + 1) % (W * (m_div + 1))) == 0) && !(m_rep && !m_stop)) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_t++;
      end
    end else begin
      m_done = 1'b0;
      if (lif.load_valid) begin
        m_active = 1'b1;
        m_t      = 0;
        m_word   = lif.load_data;
        m_rep    = lif.load_repeat;
        m_div    = int'(lif.load_div);
        m_stop   = 1'b0;
      end
    end
  endtask

  task automatic compare_outputs();
    logic exp_x;
    logic exp_s;
    exp_x = m_active ? m_word[W - 1 - ((m_t / (m_div + 1)) % W)] : 1'b0;
    exp_s = m_active && ((m_t % (m_div + 1)) == 0);
    check_bit("x",          x,              exp_x);
    check_bit("x_valid",    x_valid,        m_active);
    check_bit("busy",       busy,           m_active);
    check_bit("bit_strobe", bit_strobe,     exp_s);
    check_bit("done",       done,           m_done);
    check_bit("load_ready", lif.load_ready, !m_active);
  endtask

  // One clock: model on the rising edge, compare and collect stats on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_outputs();
    if (x_valid) begin
      vcnt++;
      cap = {cap[126:0], x};
    end
    if (bit_strobe) scnt++;
    if (done) begin
      dcnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    int n;
    int d0;
    n  = 0;
    d0 = dcnt;
    while ((dcnt == d0) && (n < max_cycles)) begin
      tick();
      n++;
    end
    check_int({name, " done seen"}, dcnt - d0, 1);
  endtask

  task automatic set_load(input logic v, input logic [W-1:0] d, input logic r, input logic [DW-1:0] dv);
    lif.load_valid  = v;
    lif.load_data   = d;
    lif.load_repeat = r;
    lif.load_div    = dv;
  endtask

  initial begin
    int c0;
    int v0;
    int s0;
    int d0;
    logic [95:0] exp96;
    logic [71:0] exp72;
    exp96 = {4'hF, 88'h0, 4'hF};
    exp72 = {3{24'h0C9094}};

    rst  = 1'b1;
    stop = 1'b0;
    set_load(1'b0, 24'h0, 1'b0, 8'd0);
    tick();
    tick();
    check_bit("reset x_valid",    x_valid,        1'b0);
    check_bit("reset load_ready", lif.load_ready, 1'b1);
    check_bit("reset done",       done,           1'b0);
    rst = 1'b0;
    tick();

    // One-shot, div=0.
    c0 = cyc; v0 = vcnt; s0 = scnt;
    set_load(1'b1, 24'hA5A5A5, 1'b0, 8'd0);
    tick();
    lif.load_valid = 1'b0;
    wait_done(40, "oneshot");
    check_int("oneshot done cycle",    done_cyc - c0, 25);
    check_int("oneshot valid cycles",  vcnt - v0,     24);
    check_int("oneshot strobes",       scnt - s0,     24);
    check_vec("oneshot bits",          {104'h0, cap[23:0]}, {104'h0, 24'hA5A5A5});
    tick();

    // div=3 one-shot with load_valid held through SHIFT, then reloaded in the done cycle.
    c0 = cyc; v0 = vcnt; s0 = scnt;
    set_load(1'b1, 24'h800001, 1'b0, 8'd3);
    tick();
    lif.load_data = 24'hC00003;
    lif.load_div  = 8'd0;
    check_bit("ready low in shift", lif.load_ready, 1'b0);
    wait_done(120, "div3");
    check_int("div3 done cycle",   done_cyc - c0, 97);
    check_int("div3 valid cycles", vcnt - v0,     96);
    check_int("div3 strobes",      scnt - s0,     24);
    check_vec("div3 bits",         {32'h0, cap[95:0]}, {32'h0, exp96});
    check_bit("gap x_valid",       x_valid, 1'b0);
    tick();
    lif.load_valid = 1'b0;
    check_bit("reload x_valid", x_valid, 1'b1);
    check_bit("reload msb",     x,       1'b1);
    wait_done(40, "reload");

    // Repeat mode, stop at bit 5 of word 3.
    tick();
    c0 = cyc; v0 = vcnt;
    set_load(1'b1, 24'h0C9094, 1'b1, 8'd0);
    tick();
    lif.load_valid = 1'b0;
    repeat (53) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(40, "repeat");
    check_int("repeat done cycle",   done_cyc - c0, 73);
    check_int("repeat valid cycles", vcnt - v0,     72);
    check_vec("repeat bits",         {56'h0, cap[71:0]}, {56'h0, exp72});

    // stop before accept is ignored in IDLE.
    stop = 1'b1;
    tick();
    tick();
    c0 = cyc; d0 = dcnt;
    set_load(1'b1, 24'h3C5A96, 1'b1, 8'd0);
    tick();
    stop = 1'b0;
    lif.load_valid = 1'b0;
    repeat (40) tick();
    check_bit("idle stop ignored", x_valid, 1'b1);
    check_int("idle stop no done", dcnt - d0, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(30, "late stop");
    check_int("late stop done cycle", done_cyc - c0, 49);

    // Reset mid-stream with load_valid held.
    tick();
    set_load(1'b1, 24'hFFFFFF, 1'b0, 8'd1);
    tick();
    lif.load_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    lif.load_valid = 1'b1;
    d0 = dcnt;
    tick();
    check_bit("rst x",          x,              1'b0);
    check_bit("rst x_valid",    x_valid,        1'b0);
    check_bit("rst busy",       busy,           1'b0);
    check_bit("rst done",       done,           1'b0);
    check_bit("rst load_ready", lif.load_ready, 1'b1);
    tick();
    rst = 1'b0;
    lif.load_valid = 1'b0;
    repeat (5) tick();
    check_int("rst no done",     dcnt - d0, 0);
    check_bit("rst no accept",   x_valid,   1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
